// File: rtl/h2f_buff_pkg.sv
// rtl/h2f_buff_pkg.sv - shared defaults, derived constants and lane helper for h2f_pingpong_buff
package h2f_buff_pkg;

    localparam int WIDE_W_DEF    = 128;
    localparam int NARROW_W_DEF  = 32;
    localparam int DEPTH_DEF     = 256;
    localparam int NUM_BANKS_DEF = 2;

    localparam int RATIO_DEF = WIDE_W_DEF / NARROW_W_DEF;
    localparam int AW_DEF    = $clog2(DEPTH_DEF);
    localparam int NAW_DEF   = AW_DEF + $clog2(RATIO_DEF);
    localparam int BW_DEF    = $clog2(NUM_BANKS_DEF);

    // Bit offset of a narrow lane inside a wide word; lane 0 is the LSB lane.
    function automatic int lane_lsb(input int lane, input int narrow_w);
        return lane * narrow_w;
    endfunction

endpackage

// File: rtl/h2f_pingpong_buff_if.sv
// rtl/h2f_pingpong_buff_if.sv - host (s1) and fabric (s2) bus bundle with bank handshake
interface h2f_pingpong_buff_if
    import h2f_buff_pkg::*;
#(
    parameter int WIDE_W    = WIDE_W_DEF,
    parameter int NARROW_W  = NARROW_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int NUM_BANKS = NUM_BANKS_DEF
);
    localparam int AW  = $clog2(DEPTH);
    localparam int NAW = AW + $clog2(WIDE_W / NARROW_W);
    localparam int BW  = $clog2(NUM_BANKS);

    logic                  s1_chipselect;
    logic                  s1_write;
    logic                  s1_read;
    logic [AW-1:0]         s1_address;
    logic [WIDE_W-1:0]     s1_writedata;
    logic [WIDE_W/8-1:0]   s1_byteenable;
    logic [WIDE_W-1:0]     s1_readdata;
    logic                  s1_readdatavalid;
    logic                  h_commit;
    logic                  h_ready;
    logic [BW-1:0]         h_bank;

    logic                  s2_chipselect;
    logic                  s2_write;
    logic                  s2_read;
    logic [NAW-1:0]        s2_address;
    logic [NARROW_W-1:0]   s2_writedata;
    logic [NARROW_W/8-1:0] s2_byteenable;
    logic [NARROW_W-1:0]   s2_readdata;
    logic                  s2_readdatavalid;
    logic                  f_release;
    logic                  f_valid;
    logic [BW-1:0]         f_bank;

    logic                  err;

    modport master (
        output s1_chipselect, s1_write, s1_read, s1_address, s1_writedata, s1_byteenable, h_commit,
        output s2_chipselect, s2_write, s2_read, s2_address, s2_writedata, s2_byteenable, f_release,
        input  s1_readdata, s1_readdatavalid, h_ready, h_bank,
        input  s2_readdata, s2_readdatavalid, f_valid, f_bank, err
    );

    modport slave (
        input  s1_chipselect, s1_write, s1_read, s1_address, s1_writedata, s1_byteenable, h_commit,
        input  s2_chipselect, s2_write, s2_read, s2_address, s2_writedata, s2_byteenable, f_release,
        output s1_readdata, s1_readdatavalid, h_ready, h_bank,
        output s2_readdata, s2_readdatavalid, f_valid, f_bank, err
    );

endinterface

// File: rtl/h2f_buff_ring_ctrl.sv
// rtl/h2f_buff_ring_ctrl.sv - bank ownership ring (host/fabric pointers, fill count, sticky error)
module h2f_buff_ring_ctrl
    import h2f_buff_pkg::*;
#(
    parameter int NUM_BANKS = NUM_BANKS_DEF,
    parameter int BW        = $clog2(NUM_BANKS)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          h_commit,
    input  logic          f_release,
    input  logic          h_access,
    input  logic          f_access,
    output logic          h_ready,
    output logic [BW-1:0] h_bank,
    output logic          f_valid,
    output logic [BW-1:0] f_bank,
    output logic          err
);
    localparam logic [BW:0] FULL = (BW+1)'(NUM_BANKS);

    logic [BW-1:0] hp, fp, hp_n, fp_n;
    logic [BW:0]   cnt, cnt_n;
    logic          err_n;
    logic          do_commit, do_release;

    assign h_ready = (cnt < FULL);
    assign f_valid = (cnt != '0);
    assign h_bank  = hp;
    assign f_bank  = fp;

    always_comb begin
        do_commit  = h_commit & h_ready;
        do_release = f_release & f_valid;
        hp_n  = do_commit  ? hp + BW'(1) : hp;
        fp_n  = do_release ? fp + BW'(1) : fp;
        cnt_n = cnt;
        case ({do_commit, do_release})
            2'b10:   cnt_n = cnt + (BW+1)'(1);
            2'b01:   cnt_n = cnt - (BW+1)'(1);
            default: cnt_n = cnt;
        endcase
        // Any handshake or access without ownership latches the error until reset.
        err_n = err | (h_commit & ~h_ready) | (f_release & ~f_valid)
                    | (h_access & ~h_ready) | (f_access & ~f_valid);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hp  <= '0;
            fp  <= '0;
            cnt <= '0;
            err <= 1'b0;
        end else begin
            hp  <= hp_n;
            fp  <= fp_n;
            cnt <= cnt_n;
            err <= err_n;
        end
    end

endmodule

// File: rtl/h2f_pingpong_buff.sv
// rtl/h2f_pingpong_buff.sv - mixed-width multi-bank host/fabric buffer; H2F_BUFF_BYTEEN_EN enables byte-enable gating
module h2f_pingpong_buff
    import h2f_buff_pkg::*;
#(
    parameter int WIDE_W    = WIDE_W_DEF,
    parameter int NARROW_W  = NARROW_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int NUM_BANKS = NUM_BANKS_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    h2f_pingpong_buff_if.slave bus
);
    localparam int RATIO = WIDE_W / NARROW_W;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = $clog2(RATIO);
    localparam int NAW   = AW + LW;
    localparam int BW    = $clog2(NUM_BANKS);
    localparam int WB    = WIDE_W / 8;
    localparam int NB    = NARROW_W / 8;

    logic h_wr, h_rd, f_wr, f_rd;
    logic [WB-1:0]    s1_be;
    logic [NB-1:0]    s2_be;
    logic [BW+AW-1:0] h_idx, f_idx;
    logic [LW-1:0]    f_lane;

    assign h_wr = bus.s1_chipselect & bus.s1_write & bus.h_ready;
    assign h_rd = bus.s1_chipselect & bus.s1_read;
    assign f_wr = bus.s2_chipselect & bus.s2_write & bus.f_valid;
    assign f_rd = bus.s2_chipselect & bus.s2_read;

    assign h_idx  = {bus.h_bank, bus.s1_address};
    assign f_idx  = {bus.f_bank, bus.s2_address[NAW-1:LW]};
    assign f_lane = bus.s2_address[LW-1:0];

`ifdef H2F_BUFF_BYTEEN_EN
    assign s1_be = bus.s1_byteenable;
    assign s2_be = bus.s2_byteenable;
`else
    assign s1_be = bus.s1_byteenable | '1;
    assign s2_be = bus.s2_byteenable | '1;
`endif

    h2f_buff_ring_ctrl #(.NUM_BANKS(NUM_BANKS), .BW(BW)) u_ring (
        .clk       (clk),
        .reset_n   (reset_n),
        .h_commit  (bus.h_commit),
        .f_release (bus.f_release),
        .h_access  (bus.s1_chipselect & (bus.s1_read | bus.s1_write)),
        .f_access  (bus.s2_chipselect & (bus.s2_read | bus.s2_write)),
        .h_ready   (bus.h_ready),
        .h_bank    (bus.h_bank),
        .f_valid   (bus.f_valid),
        .f_bank    (bus.f_bank),
        .err       (bus.err)
    );

    logic [WIDE_W-1:0] mem [NUM_BANKS*DEPTH];

    // Host and fabric banks never coincide while both own one, so both writes may land in one cycle.
    always_ff @(posedge clk) begin
        if (h_wr) begin
            for (int b = 0; b < WB; b++) begin
                if (s1_be[b]) mem[h_idx][b*8 +: 8] <= bus.s1_writedata[b*8 +: 8];
            end
        end
        if (f_wr) begin
            for (int b = 0; b < NB; b++) begin
                if (s2_be[b])
                    mem[f_idx][lane_lsb(int'(f_lane), NARROW_W) + b*8 +: 8] <= bus.s2_writedata[b*8 +: 8];
            end
        end
    end

    // Reads sample the array on the same edge as writes, giving old data for mixed-port collisions.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.s1_readdata      <= '0;
            bus.s1_readdatavalid <= 1'b0;
            bus.s2_readdata      <= '0;
            bus.s2_readdatavalid <= 1'b0;
        end else begin
            bus.s1_readdatavalid <= h_rd;
            bus.s2_readdatavalid <= f_rd;
            if (h_rd) bus.s1_readdata <= bus.h_ready ? mem[h_idx] : '0;
            if (f_rd) bus.s2_readdata <= bus.f_valid
                                         ? mem[f_idx][lane_lsb(int'(f_lane), NARROW_W) +: NARROW_W]
                                         : '0;
        end
    end

endmodule

// File: tb/tb_h2f_pingpong_buff.sv
// tb/tb_h2f_pingpong_buff.sv - scoreboard bench for h2f_pingpong_buff
module tb_h2f_pingpong_buff;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    h2f_pingpong_buff_if bus ();

    h2f_pingpong_buff dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int failures = 0;

    logic [127:0] q1 [$];
    logic [31:0]  q2 [$];
    logic exp1_v, exp2_v;

    localparam logic [127:0] PAT = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
`ifdef H2F_BUFF_BYTEEN_EN
    localparam logic [127:0] EXP_BE1 = 128'h0000_0000_0000_0000_0000_0000_0000_00FF;
    localparam logic [31:0]  EXP_BE2 = 32'hDEAD00EF;
`else
    localparam logic [127:0] EXP_BE1 = {128{1'b1}};
    localparam logic [31:0]  EXP_BE2 = 32'h0000_0000;
`endif

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Expected valids are modelled from the accepted strobes, one cycle later.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp1_v <= 1'b0;
            exp2_v <= 1'b0;
        end else begin
            exp1_v <= bus.s1_chipselect & bus.s1_read;
            exp2_v <= bus.s2_chipselect & bus.s2_read;
        end
    end

    always @(negedge clk) begin
        if (bus.s1_readdatavalid || exp1_v) begin
            check("s1_readdatavalid", 128'(bus.s1_readdatavalid), 128'(exp1_v));
            if (bus.s1_readdatavalid) begin
                if (q1.size() == 0) check("s1_queue_size", 128'(q1.size()), 128'd1);
                else check("s1_readdata", bus.s1_readdata, q1.pop_front());
            end
        end
        if (bus.s2_readdatavalid || exp2_v) begin
            check("s2_readdatavalid", 128'(bus.s2_readdatavalid), 128'(exp2_v));
            if (bus.s2_readdatavalid) begin
                if (q2.size() == 0) check("s2_queue_size", 128'(q2.size()), 128'd1);
                else check("s2_readdata", 128'(bus.s2_readdata), 128'(q2.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.s1_chipselect = 0; bus.s1_write = 0; bus.s1_read = 0;
        bus.s2_chipselect = 0; bus.s2_write = 0; bus.s2_read = 0;
        bus.h_commit = 0; bus.f_release = 0;
    endtask

    task automatic host_wr(input logic [7:0] a, input logic [127:0] d, input logic [15:0] be);
        bus.s1_chipselect = 1; bus.s1_write = 1; bus.s1_address = a;
        bus.s1_writedata = d; bus.s1_byteenable = be;
        tick();
        idle();
    endtask

    task automatic host_rd(input logic [7:0] a, input logic [127:0] exp);
        bus.s1_chipselect = 1; bus.s1_read = 1; bus.s1_address = a;
        q1.push_back(exp);
        tick();
        idle();
    endtask

    task automatic fab_wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.s2_chipselect = 1; bus.s2_write = 1; bus.s2_address = a;
        bus.s2_writedata = d; bus.s2_byteenable = be;
        tick();
        idle();
    endtask

    task automatic fab_rd(input logic [9:0] a, input logic [31:0] exp);
        bus.s2_chipselect = 1; bus.s2_read = 1; bus.s2_address = a;
        q2.push_back(exp);
        tick();
        idle();
    endtask

    task automatic hs(input logic c, input logic r);
        bus.h_commit = c; bus.f_release = r;
        tick();
        idle();
    endtask

    task automatic status(input string tag, input logic hr, input logic hb,
                          input logic fv, input logic fb, input logic e);
        check({tag, "_h_ready"}, 128'(bus.h_ready), 128'(hr));
        check({tag, "_h_bank"},  128'(bus.h_bank),  128'(hb));
        check({tag, "_f_valid"}, 128'(bus.f_valid), 128'(fv));
        check({tag, "_f_bank"},  128'(bus.f_bank),  128'(fb));
        check({tag, "_err"},     128'(bus.err),     128'(e));
    endtask

    initial begin
        idle();
        bus.s1_address = '0; bus.s1_writedata = '0; bus.s1_byteenable = '0;
        bus.s2_address = '0; bus.s2_writedata = '0; bus.s2_byteenable = '0;
        repeat (3) @(posedge clk);
        #1;
        status("reset", 1, 0, 0, 0, 0);
        check("reset_s1_readdata", bus.s1_readdata, 128'd0);
        check("reset_s1_rvalid", 128'(bus.s1_readdatavalid), 128'd0);
        check("reset_s2_readdata", 128'(bus.s2_readdata), 128'd0);
        reset_n = 1'b1;
        tick();

        host_wr(8'd5, 128'd0, 16'hFFFF);
        host_wr(8'd3, PAT, 16'hFFFF);
        host_rd(8'd3, PAT);
        hs(1, 0);
        status("commit1", 1, 1, 1, 0, 0);

        fab_rd(10'd12, 32'h03020100);
        fab_rd(10'd13, 32'h07060504);
        fab_rd(10'd14, 32'h0B0A0908);
        fab_rd(10'd15, 32'h0F0E0D0C);

        fab_wr(10'd22, 32'hDEADBEEF, 4'hF);
        fab_rd(10'd22, 32'hDEADBEEF);

        host_wr(8'd5, {4{32'h11111111}}, 16'hFFFF);
        hs(1, 0);
        status("full", 0, 0, 1, 0, 0);

        host_wr(8'd3, {128{1'b1}}, 16'hFFFF);
        check("dropped_write_err", 128'(bus.err), 128'd1);
        host_rd(8'd3, 128'd0);
        fab_rd(10'd12, 32'h03020100);

        hs(0, 1);
        status("release1", 1, 0, 1, 1, 1);
        host_rd(8'd5, {32'h0, 32'hDEADBEEF, 64'h0});
        fab_rd(10'd20, 32'h11111111);

        hs(1, 1);
        status("simul", 1, 1, 1, 0, 1);

        host_wr(8'd7, 128'd0, 16'hFFFF);
        host_wr(8'd7, {128{1'b1}}, 16'h0001);
        host_rd(8'd7, EXP_BE1);
        fab_wr(10'd22, 32'h0, 4'h2);
        fab_rd(10'd22, EXP_BE2);

        hs(0, 1);
        status("empty", 1, 1, 0, 1, 1);
        hs(0, 1);
        check("illegal_release_f_bank", 128'(bus.f_bank), 128'd1);
        fab_rd(10'd0, 32'h0);

        hs(1, 0);
        check("pre_reset_f_valid", 128'(bus.f_valid), 128'd1);
        tick();
        bus.s1_chipselect = 1; bus.s1_read = 1; bus.s1_address = 8'd3;
        @(posedge clk);
        #1;
        idle();
        reset_n = 1'b0;
        @(negedge clk);
        check("squash_rvalid", 128'(bus.s1_readdatavalid), 128'd0);
        status("midreset", 1, 0, 0, 0, 0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();

        check("q1_drained", 128'(q1.size()), 128'd0);
        check("q2_drained", 128'(q2.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/h2f_pingpong_buff.md
# h2f_pingpong_buff

Parametrised mixed-width multi-bank buffer between the HPS wide Avalon-MM slave and the fabric compute datapath. The host fills one bank through a wide port while the fabric reads or writes back another bank through a narrow port. Banks change owner through a commit/release handshake, so the two sides never touch the same bank. Optional per-byte write enables are supported. It replaces the fixed 128/32-bit single-bank buffer in the SoC system.

## Interface
- WIDE_W, 128: host data width; must equal NARROW_W × RATIO, with RATIO a power of 2.
- NARROW_W, 32: fabric data width.
- DEPTH, 256: wide words per bank; power of 2.
- NUM_BANKS, 2: bank count; power of 2, ≥2.
- Derived: RATIO=WIDE_W/NARROW_W, AW=clog2(DEPTH), NAW=AW+clog2(RATIO), BW=clog2(NUM_BANKS).

Ports:
- clk  in  1  single clock for the whole block.
- reset_n  in  1  asynchronous, active-low reset.
- s1_chipselect, s1_write, s1_read  in  1  host strobes.
- s1_address  in  AW  wide-word address within the host bank.
- s1_writedata  in  WIDE_W; s1_byteenable  in  WIDE_W/8.
- s1_readdata  out  WIDE_W; s1_readdatavalid  out  1.
- h_commit  in  1  pulse: host bank is complete.
- h_ready  out  1  host owns a writable bank; h_bank  out  BW  its index.
- s2_chipselect, s2_write, s2_read  in  1  fabric strobes.
- s2_address  in  NAW  narrow-word address within the fabric bank.
- s2_writedata  in  NARROW_W; s2_byteenable  in  NARROW_W/8.
- s2_readdata  out  NARROW_W; s2_readdatavalid  out  1.
- f_release  in  1  pulse: fabric is done with its bank.
- f_valid  out  1  fabric owns a filled bank; f_bank  out  BW  its index.
- err  out  1  sticky protocol error; cleared only by reset.

## Operation
- Storage is NUM_BANKS×DEPTH wide words. Narrow lane = s2_address[clog2(RATIO)-1:0]; lane 0 maps to bits [NARROW_W-1:0].
- Ring control state: host pointer hp, fabric pointer fp (both BW bits, wrapping modulo NUM_BANKS), and count cnt (0..NUM_BANKS).
- h_ready = (cnt < NUM_BANKS), h_bank = hp; f_valid = (cnt > 0), f_bank = fp.
- h_commit with h_ready: hp+1, cnt+1.
- f_release with f_valid: fp+1, cnt-1.
- Simultaneous commit and release (both legal): both pointers advance and cnt is unchanged.
- h_commit while !h_ready, or f_release while !f_valid: ignored and err set.
- Host access while !h_ready: writes dropped, reads return 0 with valid, err set. The same rule applies to fabric access while !f_valid.
- Host and fabric banks are always distinct when both are legal, so there is no same-address collision. Mixed-port read-during-write returns old data.
- Write in the same cycle as commit/release targets the pre-update bank. Reads likewise latch the bank at acceptance.

## Timing
- Reads: accepted in cycle N; readdata and readdatavalid are registered and valid in cycle N+1 only. Pipelined back-to-back reads are supported.
- Writes complete in 1 cycle; a read of the same address in the next cycle returns the new data.
- h_ready, f_valid, h_bank and f_bank update in the cycle after commit/release.
- Reset values: hp=fp=0, cnt=0, h_ready=1, h_bank=0, f_valid=0, f_bank=0, readdata=0, readdatavalid=0, err=0. Memory contents are not reset.
- Reset mid-operation: all banks return to free, and any pending readdatavalid is squashed.

## Configuration
- H2F_BUFF_BYTEEN_EN defined: s1_byteenable and s2_byteenable gate writes per byte.
- Undefined: byteenable ports remain present but are ignored; every write is full-word (all lanes of the selected word on the narrow port).

## Structure
- Package h2f_buff_pkg holds the width/depth defaults, clog2-derived constants, and a lane-select function.
- Sub-module h2f_buff_ring_ctrl holds hp, fp, cnt, the handshake outputs and err.
- Top level holds the memory array and the read pipelines.

## Test plan
- Reset, then host writes 128'h0F0E…00 to bank0 addr 3, commits. Fabric reads addr 12..15 → 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C, each with valid 1 cycle later.
- Host commits twice with NUM_BANKS=2 → h_ready=0 after the second commit. A third write is dropped and err=1.
- Commit and release in the same cycle with cnt=1 → cnt stays 1, and h_bank and f_bank both advance.
- Fabric writes 32'hDEADBEEF to lane 2 of addr 5, releases; after the host cycles back to that bank, the host reads addr 5 → bits [95:64]=DEADBEEF.
- With the macro defined: s1 write with byteenable=16'h0001, data all FF over a zero word → readback 128'h…00FF. With the macro undefined → all FF.
- Assert reset_n low while a read is pending → readdatavalid=0, f_valid=0, h_ready=1 next cycle.
